// File: rtl/jtag_reg_arbiter.sv
// jtag_reg_arbiter
//   Register-bank controller behind a BSCANE2 user-chain shift register.
//   Synchronises the JTAG update strobe into clk, captures the shifted command,
//   and round-robin arbitrates it against a local requester for one shared bank
//   of 2^IDX_W x DATA_W config registers.
// Ports
//   clk, reset_n                    fabric clock, async active-low reset
//   jtag_update_i                   update strobe from the DRCK domain (async)
//   jtag_addr_i / jtag_data_i       shifted command: [IDX_W]=write, [IDX_W-1:0]=index
//   jtag_rdata_o / jtag_raddr_o     read-back data / echo of last executed JTAG command
//   loc_valid_i .. loc_wdata_i      local request (held until loc_ready_o)
//   loc_ready_o                     local request accepted this cycle
//   loc_rvalid_o / loc_rdata_o      one-cycle response pulse with data
//   cfg_o                           flat bank contents, reg i at [i*DATA_W +: DATA_W]
//   ovf_o / ovf_clr_i               sticky dropped-JTAG-command flag and its clear
module jtag_reg_arbiter #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned IDX_W       = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        jtag_update_i,
   input  logic [IDX_W:0]              jtag_addr_i,
   input  logic [DATA_W-1:0]           jtag_data_i,
   output logic [DATA_W-1:0]           jtag_rdata_o,
   output logic [IDX_W:0]              jtag_raddr_o,
   input  logic                        loc_valid_i,
   input  logic                        loc_we_i,
   input  logic [IDX_W-1:0]            loc_idx_i,
   input  logic [DATA_W-1:0]           loc_wdata_i,
   output logic                        loc_ready_o,
   output logic                        loc_rvalid_o,
   output logic [DATA_W-1:0]           loc_rdata_o,
   output logic [(DATA_W<<IDX_W)-1:0]  cfg_o,
   output logic                        ovf_o,
   input  logic                        ovf_clr_i
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_J = 2'd1,
      S_GRANT_L = 2'd2
   } state_t;

   state_t                r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                  r_sync_d;
   logic                  r_pend;
   logic                  r_last_j;
   logic [IDX_W:0]        r_cap_addr;
   logic [DATA_W-1:0]     r_cap_data;
   logic [DATA_W-1:0]     r_bank [DEPTH];

   logic                  w_jreq;
   logic                  w_ovf_set;
   logic                  w_cap_we;
   logic [IDX_W-1:0]      w_cap_idx;

   assign w_jreq    = r_sync[SYNC_STAGES-1] & ~r_sync_d;
   // A strobe during GRANT_J is not an overflow: the pending command is being consumed.
   assign w_ovf_set = w_jreq & r_pend & (r_state != S_GRANT_J);
   assign w_cap_we  = r_cap_addr[IDX_W];
   assign w_cap_idx = r_cap_addr[IDX_W-1:0];

   // Update-strobe synchroniser and rising-edge detector
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync   <= '0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], jtag_update_i};
         r_sync_d <= r_sync[SYNC_STAGES-1];
      end
   end

   // Command capture, overflow flag, arbitration FSM and bank access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_pend       <= 1'b0;
         r_last_j     <= 1'b0;
         r_cap_addr   <= '0;
         r_cap_data   <= '0;
         jtag_rdata_o <= '0;
         jtag_raddr_o <= '0;
         loc_ready_o  <= 1'b0;
         loc_rvalid_o <= 1'b0;
         loc_rdata_o  <= '0;
         ovf_o        <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_bank[i] <= '0;
         end
      end else begin
         loc_ready_o  <= 1'b0;
         loc_rvalid_o <= 1'b0;

         if (w_jreq && !w_ovf_set) begin
            r_cap_addr <= jtag_addr_i;
            r_cap_data <= jtag_data_i;
            r_pend     <= 1'b1;
         end else if (r_state == S_GRANT_J) begin
            r_pend <= 1'b0;
         end

         if (w_ovf_set) begin
            ovf_o <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               // On contention the side that did not win last time is granted.
               if (r_pend && (!loc_valid_i || !r_last_j)) begin
                  r_state <= S_GRANT_J;
               end else if (loc_valid_i) begin
                  r_state     <= S_GRANT_L;
                  loc_ready_o <= 1'b1;
               end
            end
            S_GRANT_J: begin
               if (w_cap_we) begin
                  r_bank[w_cap_idx] <= r_cap_data;
                  jtag_rdata_o      <= r_cap_data;
               end else begin
                  jtag_rdata_o <= r_bank[w_cap_idx];
               end
               jtag_raddr_o <= r_cap_addr;
               r_last_j     <= 1'b1;
               r_state      <= S_IDLE;
            end
            S_GRANT_L: begin
               if (loc_we_i) begin
                  r_bank[loc_idx_i] <= loc_wdata_i;
                  loc_rdata_o       <= loc_wdata_i;
               end else begin
                  loc_rdata_o <= r_bank[loc_idx_i];
               end
               loc_rvalid_o <= 1'b1;
               r_last_j     <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Flatten bank for the config consumers
   always_comb begin
      cfg_o = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cfg_o[i*DATA_W +: DATA_W] = r_bank[i];
      end
   end

endmodule

// File: tb/tb_jtag_reg_arbiter.sv
// tb_jtag_reg_arbiter
//   Scoreboard bench for jtag_reg_arbiter: local responses are predicted when a
//   request is accepted and compared when loc_rvalid_o pulses; JTAG results are
//   predicted when the command is shifted in and compared after the sync latency.
module tb_jtag_reg_arbiter;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DEPTH  = 1 << IDX_W;
   localparam int unsigned CFG_W  = DATA_W << IDX_W;

   typedef struct packed {
      logic [IDX_W:0]    addr;
      logic [DATA_W-1:0] data;
   } jexp_t;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                jtag_update_i;
   logic [IDX_W:0]      jtag_addr_i;
   logic [DATA_W-1:0]   jtag_data_i;
   logic [DATA_W-1:0]   jtag_rdata_o;
   logic [IDX_W:0]      jtag_raddr_o;
   logic                loc_valid_i;
   logic                loc_we_i;
   logic [IDX_W-1:0]    loc_idx_i;
   logic [DATA_W-1:0]   loc_wdata_i;
   logic                loc_ready_o;
   logic                loc_rvalid_o;
   logic [DATA_W-1:0]   loc_rdata_o;
   logic [CFG_W-1:0]    cfg_o;
   logic                ovf_o;
   logic                ovf_clr_i;

   int unsigned         n_total = 0;
   int unsigned         n_bad   = 0;
   logic [DATA_W-1:0]   m_bank [DEPTH];
   logic [DATA_W-1:0]   lq [$];
   jexp_t               jq [$];

   jtag_reg_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .jtag_update_i (jtag_update_i),
      .jtag_addr_i   (jtag_addr_i),
      .jtag_data_i   (jtag_data_i),
      .jtag_rdata_o  (jtag_rdata_o),
      .jtag_raddr_o  (jtag_raddr_o),
      .loc_valid_i   (loc_valid_i),
      .loc_we_i      (loc_we_i),
      .loc_idx_i     (loc_idx_i),
      .loc_wdata_i   (loc_wdata_i),
      .loc_ready_o   (loc_ready_o),
      .loc_rvalid_o  (loc_rvalid_o),
      .loc_rdata_o   (loc_rdata_o),
      .cfg_o         (cfg_o),
      .ovf_o         (ovf_o),
      .ovf_clr_i     (ovf_clr_i)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [CFG_W-1:0] model_flat();
      logic [CFG_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(DEPTH); i++) r[i*DATA_W +: DATA_W] = m_bank[i];
      return r;
   endfunction

   // Local-side scoreboard: predict on acceptance, compare on response
   always @(negedge clk) begin
      if (reset_n) begin
         if (loc_rvalid_o) begin
            if (lq.size() == 0) check_eq("loc_rvalid_unexpected", 64'd1, 64'd0);
            else check_eq("loc_rdata", 64'(loc_rdata_o), 64'(lq.pop_front()));
         end
         if (loc_ready_o) begin
            check_eq("ready_needs_valid", 64'(loc_valid_i), 64'd1);
            if (loc_we_i) begin
               m_bank[loc_idx_i] = loc_wdata_i;
               lq.push_back(loc_wdata_i);
            end else begin
               lq.push_back(m_bank[loc_idx_i]);
            end
         end
      end
   end

   task automatic wait_ready(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (loc_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   // Caller is just after a rising edge; strobe held 3 cycles so capture sees a stable bus
   task automatic jtag_cmd(input logic [IDX_W:0] a, input logic [DATA_W-1:0] d);
      jexp_t e;
      jtag_addr_i   = a;
      jtag_data_i   = d;
      jtag_update_i = 1'b1;
      e.addr = a;
      if (a[IDX_W]) begin
         m_bank[a[IDX_W-1:0]] = d;
         e.data = d;
      end else begin
         e.data = m_bank[a[IDX_W-1:0]];
      end
      jq.push_back(e);
      repeat (3) @(posedge clk);
      #1 jtag_update_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic jtag_check(input string tag);
      jexp_t e;
      repeat (6) @(posedge clk);
      #1;
      if (jq.size() == 0) begin
         check_eq({tag, "_noexp"}, 64'd0, 64'd1);
         return;
      end
      e = jq[$];
      jq.delete();
      check_eq({tag, "_raddr"}, 64'(jtag_raddr_o), 64'(e.addr));
      check_eq({tag, "_rdata"}, 64'(jtag_rdata_o), 64'(e.data));
   endtask

   task automatic loc_req(input logic we, input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
      loc_we_i    = we;
      loc_idx_i   = idx;
      loc_wdata_i = d;
      loc_valid_i = 1'b1;
      wait_ready("loc_req");
      @(posedge clk);
      #1 loc_valid_i = 1'b0;
      @(negedge clk);
      check_eq("ready_one_cycle", 64'(loc_ready_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_lat;
      logic [CFG_W-1:0] flat;
      reset_n = 1'b0; jtag_update_i = 1'b0; jtag_addr_i = '0; jtag_data_i = '0;
      loc_valid_i = 1'b0; loc_we_i = 1'b0; loc_idx_i = '0; loc_wdata_i = '0; ovf_clr_i = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) m_bank[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cfg", 64'(cfg_o), 64'd0);
      check_eq("rst_ovf", 64'(ovf_o), 64'd0);
      check_eq("rst_rdata", 64'(jtag_rdata_o), 64'd0);
      check_eq("rst_raddr", 64'(jtag_raddr_o), 64'd0);
      check_eq("rst_ready", 64'(loc_ready_o), 64'd0);
      check_eq("rst_rvalid", 64'(loc_rvalid_o), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Tie after reset: JTAG first, then local (local read of JTAG-written reg sees new value)
      jtag_addr_i = 4'b1_001; jtag_data_i = 8'h11; jtag_update_i = 1'b1;
      m_bank[1] = 8'h11;
      repeat (3) @(posedge clk);
      #1 jtag_update_i = 1'b0;
      loc_we_i = 1'b0; loc_idx_i = 3'd1; loc_valid_i = 1'b1;
      n_lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (loc_ready_o) begin
            n_lat = i;
            break;
         end
      end
      check_eq("tie_local_latency", 64'(n_lat), 64'd4);
      check_eq("tie_jtag_first_raddr", 64'(jtag_raddr_o), 64'h9);
      check_eq("tie_jtag_first_rdata", 64'(jtag_rdata_o), 64'h11);
      @(posedge clk);
      #1 loc_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // JTAG write then read back
      jtag_cmd(4'b1_101, 8'hA5);
      jtag_check("jwr");
      jtag_cmd(4'b0_101, 8'h00);
      jtag_check("jrd");
      check_eq("jrd_cfg5", 64'(cfg_o[47:40]), 64'hA5);

      // Local write then read
      loc_req(1'b1, 3'd2, 8'h3C);
      loc_req(1'b0, 3'd2, 8'h00);
      check_eq("lwr_cfg2", 64'(cfg_o[23:16]), 64'h3C);

      // Both sides loaded: every JTAG command lands, no overflow
      loc_we_i = 1'b0; loc_idx_i = 3'd1; loc_valid_i = 1'b1;
      for (int k = 0; k < 4; k++) jtag_cmd({1'b1, 3'(4 + k)}, 8'(8'h40 + k));
      jtag_check("alt");
      wait_ready("alt_drop");
      @(posedge clk);
      #1 loc_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("alt_no_ovf", 64'(ovf_o), 64'd0);
      flat = model_flat();
      check_eq("alt_cfg", 64'(cfg_o), 64'(flat));

      // Overflow: second strobe arrives while first command still pending
      loc_we_i = 1'b0; loc_idx_i = 3'd1; loc_valid_i = 1'b1;
      wait_ready("ovf_align");
      @(posedge clk);
      #1;
      jtag_addr_i = 4'b1_110; jtag_data_i = 8'h77; jtag_update_i = 1'b1;
      m_bank[6] = 8'h77;
      jq.push_back(jexp_t'({4'b1_110, 8'h77}));
      @(posedge clk);
      #1 jtag_update_i = 1'b0;
      @(posedge clk);
      #1 jtag_update_i = 1'b1;
      @(posedge clk);
      #1 jtag_addr_i = 4'b1_111; jtag_data_i = 8'h99;
      repeat (3) @(posedge clk);
      #1 jtag_update_i = 1'b0;
      check_eq("ovf_set", 64'(ovf_o), 64'd1);
      jtag_check("ovf_first_cmd");
      wait_ready("ovf_drop");
      @(posedge clk);
      #1 loc_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      flat = model_flat();
      check_eq("ovf_cfg", 64'(cfg_o), 64'(flat));
      check_eq("ovf_sticky", 64'(ovf_o), 64'd1);
      ovf_clr_i = 1'b1;
      @(posedge clk);
      #1 ovf_clr_i = 1'b0;
      check_eq("ovf_clr", 64'(ovf_o), 64'd0);

      // Reset during GRANT_L
      loc_we_i = 1'b1; loc_idx_i = 3'd3; loc_wdata_i = 8'h5A; loc_valid_i = 1'b1;
      wait_ready("rst_mid");
      #2 reset_n = 1'b0;
      #1;
      check_eq("rstmid_ready", 64'(loc_ready_o), 64'd0);
      check_eq("rstmid_rvalid", 64'(loc_rvalid_o), 64'd0);
      check_eq("rstmid_lrdata", 64'(loc_rdata_o), 64'd0);
      check_eq("rstmid_jrdata", 64'(jtag_rdata_o), 64'd0);
      check_eq("rstmid_raddr", 64'(jtag_raddr_o), 64'd0);
      check_eq("rstmid_cfg", 64'(cfg_o), 64'd0);
      check_eq("rstmid_ovf", 64'(ovf_o), 64'd0);
      lq.delete();
      jq.delete();
      for (int i = 0; i < int'(DEPTH); i++) m_bank[i] = '0;
      loc_valid_i = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("rstmid_no_rvalid", 64'(loc_rvalid_o), 64'd0);
      end
      check_eq("rstmid_cfg_after", 64'(cfg_o), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
